// File: rtl/readcode_burst_ctrl_pkg.sv
// Shared types and constants for the readcode line-fill burst controller.
package readcode_burst_ctrl_pkg;

  localparam int unsigned RC_BURST_LEN = 4;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned LINE_W       = DATA_W * RC_BURST_LEN;
  localparam int unsigned AVM_ADDR_W   = 30;
  localparam int unsigned BURST_W      = 3;
  localparam int unsigned IDX_W        = 2;

  typedef enum logic [1:0] {
    RC_IDLE = 2'd0,
    RC_CMD  = 2'd1,
    RC_DATA = 2'd2,
    RC_DONE = 2'd3
  } rc_state_e;

  // Dword address of the first dword of the 16-byte line holding byte_addr.
  function automatic logic [AVM_ADDR_W-1:0] line_dword_addr(input logic [31:0] byte_addr);
    return {byte_addr[31:4], 2'b00};
  endfunction

endpackage

// File: rtl/readcode_burst_ctrl_if.sv
// Readcode request link plus Avalon-MM read port of the line-fill controller.
interface readcode_burst_ctrl_if;
  import readcode_burst_ctrl_pkg::*;

  logic                  readcode_do;
  logic [31:0]           readcode_address;
  logic                  readcode_done;
  logic [LINE_W-1:0]     readcode_line;
  logic [DATA_W-1:0]     readcode_partial;
  logic                  readcode_partial_done;
  logic [AVM_ADDR_W-1:0] avm_address;
  logic                  avm_read;
  logic [BURST_W-1:0]    avm_burstcount;
  logic                  avm_waitrequest;
  logic [DATA_W-1:0]     avm_readdata;
  logic                  avm_readdatavalid;

  // Controller side.
  modport slave (
    input  readcode_do, readcode_address,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid,
    output readcode_done, readcode_line, readcode_partial, readcode_partial_done,
    output avm_address, avm_read, avm_burstcount
  );

  // Requester / memory side.
  modport master (
    output readcode_do, readcode_address,
    output avm_waitrequest, avm_readdata, avm_readdatavalid,
    input  readcode_done, readcode_line, readcode_partial, readcode_partial_done,
    input  avm_address, avm_read, avm_burstcount
  );

endinterface

// File: rtl/readcode_burst_ctrl.sv
// Fetches one 16-byte code line as a 4-beat Avalon burst, streaming the
// requested dword and those after it as partials, then pulsing done.
module readcode_burst_ctrl
  import readcode_burst_ctrl_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  readcode_burst_ctrl_if.slave bus
);

  rc_state_e             state_q, state_d;
  logic [IDX_W-1:0]      cnt_q;
  logic [IDX_W-1:0]      start_idx_q;
  logic [DATA_W-1:0]     line_q [RC_BURST_LEN];
  logic [DATA_W-1:0]     partial_q;
  logic                  partial_done_q;
  logic                  done_q;
  logic                  avm_read_q;
  logic [AVM_ADDR_W-1:0] avm_address_q;
  logic [BURST_W-1:0]    avm_burstcount_q;
  logic                  start_c;
  logic                  beat_c;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RC_IDLE;
    else        state_q <= state_d;
  end

  // Next state, request capture and beat qualification.
  always_comb begin
    state_d = state_q;
    start_c = 1'b0;
    beat_c  = 1'b0;
    case (state_q)
      RC_IDLE: begin
        if (bus.readcode_do) begin
          start_c = 1'b1;
          state_d = RC_CMD;
        end
      end
      RC_CMD: begin
        beat_c = bus.avm_readdatavalid;
        if (avm_read_q && !bus.avm_waitrequest) state_d = RC_DATA;
      end
      RC_DATA: beat_c = bus.avm_readdatavalid;
      RC_DONE: state_d = RC_IDLE;
      default: state_d = RC_IDLE;
    endcase
    // Last beat of the line wins over any other transition.
    if (beat_c && (cnt_q == IDX_W'(RC_BURST_LEN - 1))) state_d = RC_DONE;
  end

  // Registered outputs, line assembly and beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q            <= '0;
      start_idx_q      <= '0;
      avm_address_q    <= '0;
      avm_read_q       <= 1'b0;
      avm_burstcount_q <= '0;
      partial_q        <= '0;
      partial_done_q   <= 1'b0;
      done_q           <= 1'b0;
      for (int i = 0; i < RC_BURST_LEN; i++) line_q[i] <= '0;
    end else begin
      avm_read_q       <= (state_d == RC_CMD);
      avm_burstcount_q <= (state_d == RC_CMD) ? BURST_W'(RC_BURST_LEN) : '0;
      done_q           <= (state_d == RC_DONE);
      partial_done_q   <= 1'b0;
      if (start_c) begin
        avm_address_q <= line_dword_addr(bus.readcode_address);
        start_idx_q   <= bus.readcode_address[3:2];
        cnt_q         <= '0;
      end
      if (beat_c) begin
        line_q[cnt_q] <= bus.avm_readdata;
        cnt_q         <= cnt_q + IDX_W'(1);
        // Dwords before the requested one fill the line silently.
        if (cnt_q >= start_idx_q) begin
          partial_q      <= bus.avm_readdata;
          partial_done_q <= 1'b1;
        end
      end
    end
  end

  assign bus.readcode_done         = done_q;
  assign bus.readcode_line         = {line_q[3], line_q[2], line_q[1], line_q[0]};
  assign bus.readcode_partial      = partial_q;
  assign bus.readcode_partial_done = partial_done_q;
  assign bus.avm_address           = avm_address_q;
  assign bus.avm_read              = avm_read_q;
  assign bus.avm_burstcount        = avm_burstcount_q;

endmodule

// File: tb/tb_readcode_burst_ctrl.sv
// Scoreboard bench for readcode_burst_ctrl: a driver acts as requester and
// Avalon slave, a monitor compares every output event against expectations.
module tb_readcode_burst_ctrl;
  import readcode_burst_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  readcode_burst_ctrl_if bus();

  readcode_burst_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  logic [31:0]  exp_partial_q[$];
  logic [127:0] exp_line_q[$];
  logic [29:0]  exp_addr_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event missing or unexpected (t=%0t)", name, $time);
  endtask

  // Monitor: checks every output event sampled on the falling edge.
  initial begin
    logic        prev_stall, prev_done;
    logic        prev_read;
    logic [29:0] prev_addr;
    logic [2:0]  prev_bc;
    prev_stall = 1'b0; prev_done = 1'b0; prev_read = 1'b0;
    prev_addr = '0; prev_bc = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        prev_done  = 1'b0;
      end else begin
        check("burstcount", 128'(bus.avm_burstcount), bus.avm_read ? 128'd4 : 128'd0);
        if (prev_stall) begin
          check("stall_read", 128'(bus.avm_read), 128'(prev_read));
          check("stall_addr", 128'(bus.avm_address), 128'(prev_addr));
          check("stall_bc", 128'(bus.avm_burstcount), 128'(prev_bc));
        end
        if (bus.avm_read && !bus.avm_waitrequest) begin
          if (exp_addr_q.size() == 0) fail_now("cmd_unexpected");
          else check("avm_address", 128'(bus.avm_address), 128'(exp_addr_q.pop_front()));
        end
        if (prev_done) begin
          check("idle_after_done", 128'(bus.avm_read), 128'd0);
          check("done_single", 128'(bus.readcode_done), 128'd0);
        end
        if (bus.readcode_partial_done) begin
          if (exp_partial_q.size() == 0) fail_now("partial_unexpected");
          else check("partial", 128'(bus.readcode_partial), 128'(exp_partial_q.pop_front()));
        end
        if (bus.readcode_done) begin
          check("last_partial_with_done", 128'(bus.readcode_partial_done), 128'd1);
          if (exp_line_q.size() == 0) fail_now("done_unexpected");
          else check("line", bus.readcode_line, exp_line_q.pop_front());
        end
        prev_stall = bus.avm_read && bus.avm_waitrequest;
        prev_done  = bus.readcode_done;
        prev_read  = bus.avm_read;
        prev_addr  = bus.avm_address;
        prev_bc    = bus.avm_burstcount;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_done"}, 128'(bus.readcode_done), 128'd0);
    check({tag, "_pdone"}, 128'(bus.readcode_partial_done), 128'd0);
    check({tag, "_partial"}, 128'(bus.readcode_partial), 128'd0);
    check({tag, "_line"}, bus.readcode_line, 128'd0);
    check({tag, "_read"}, 128'(bus.avm_read), 128'd0);
    check({tag, "_addr"}, 128'(bus.avm_address), 128'd0);
    check({tag, "_bc"}, 128'(bus.avm_burstcount), 128'd0);
  endtask

  task automatic idle(input int n);
    bus.readcode_do = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One line request: requester holds do, slave stalls wait_k cycles then
  // returns data with gap idle cycles before each beat (gap<0: random).
  task automatic burst(input logic [31:0] addr, input logic [127:0] data, input int wait_k,
                       input int gap, input bit abort, input bit chk_lat);
    int s, nbeats, gp, n;
    int unsigned t0;
    s      = int'((addr >> 2) % 4);
    nbeats = abort ? 2 : 4;
    exp_addr_q.push_back(30'(addr >> 4) << 2);
    for (int b = 0; b < nbeats; b++)
      if (b >= s) exp_partial_q.push_back(data[32*b +: 32]);
    if (!abort) exp_line_q.push_back(data);

    bus.readcode_do      = 1'b1;
    bus.readcode_address = addr;
    t0 = cyc;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!bus.avm_read && n < 50);
    if (!bus.avm_read) begin fail_now("cmd_timeout"); return; end

    bus.avm_waitrequest = (wait_k > 0);
    for (int i = 0; i < wait_k; i++) begin @(posedge clk); #1; end
    bus.avm_waitrequest = 1'b0;
    @(posedge clk); #1;
    check("read_drop", 128'(bus.avm_read), 128'd0);

    for (int b = 0; b < nbeats; b++) begin
      gp = (gap < 0) ? int'($urandom_range(3, 0)) : gap;
      repeat (gp) begin @(posedge clk); #1; end
      bus.avm_readdatavalid = 1'b1;
      bus.avm_readdata      = data[32*b +: 32];
      @(posedge clk); #1;
      bus.avm_readdatavalid = 1'b0;
      bus.avm_readdata      = $urandom;
    end

    if (!abort) begin
      check("done_after_last_beat", 128'(bus.readcode_done), 128'd1);
      if (chk_lat) check("latency_edges", 128'(cyc - t0), 128'd6);
    end else begin
      @(posedge clk); #1;
      rst_n = 1'b0;
      bus.readcode_do = 1'b0;
      #1;
      check_all_zero("midreset");
      check("midreset_partials_left", 128'(exp_partial_q.size()), 128'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
    end
  endtask

  // Stray beats while idle must be ignored.
  task automatic stray_beats(input int n);
    bus.readcode_do = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.avm_readdatavalid = 1'b1;
      bus.avm_readdata      = $urandom;
      @(posedge clk); #1;
      check("stray_pdone", 128'(bus.readcode_partial_done), 128'd0);
      check("stray_done", 128'(bus.readcode_done), 128'd0);
      check("stray_read", 128'(bus.avm_read), 128'd0);
    end
    bus.avm_readdatavalid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d;
    bus.readcode_do       = 1'b0;
    bus.readcode_address  = '0;
    bus.avm_waitrequest   = 1'b0;
    bus.avm_readdata      = '0;
    bus.avm_readdatavalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    idle(2);

    d = {32'h44, 32'h33, 32'h22, 32'h11};
    burst(32'h0000_1000, d, 0, 0, 1'b0, 1'b1);
    idle(2);
    burst(32'h0000_100C, d, 0, 0, 1'b0, 1'b0);
    idle(2);
    burst(32'h0000_1000, {$urandom, $urandom, $urandom, $urandom}, 5, 0, 1'b0, 1'b0);
    idle(2);
    burst(32'h0000_3008, {$urandom, $urandom, $urandom, $urandom}, 1, 3, 1'b0, 1'b0);
    idle(2);
    burst(32'h0000_1004, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 1'b0, 1'b0);
    burst(32'h0000_2004, {$urandom, $urandom, $urandom, $urandom}, 0, 1, 1'b0, 1'b0);
    idle(2);
    burst(32'h0000_4000, {$urandom, $urandom, $urandom, $urandom}, 2, 1, 1'b1, 1'b0);
    stray_beats(3);
    burst(32'h0000_5008, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 1'b0, 1'b0);
    idle(2);

    for (int i = 0; i < 40; i++) begin
      burst($urandom, {$urandom, $urandom, $urandom, $urandom},
            int'($urandom_range(4, 0)), -1, 1'b0, 1'b0);
      if ($urandom_range(1, 0) == 1) idle(int'($urandom_range(3, 1)));
    end
    idle(4);

    check("partials_left", 128'(exp_partial_q.size()), 128'd0);
    check("lines_left", 128'(exp_line_q.size()), 128'd0);
    check("cmds_left", 128'(exp_addr_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
